// File: rtl/nibble_link_target_bridge.sv
// Target side of the narrow memory link: gathers LSB-first link beats into one
// memory request, then streams the memory response back out as link beats.
module nibble_link_target_bridge #(
  parameter int unsigned LinkWidth = 4,
  parameter int unsigned AddrWidth = 10,
  parameter int unsigned DataWidth = 32,
  parameter bit          WriteRsp  = 1'b0
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic [LinkWidth-1:0]   link_q_data_i,
  input  logic                   link_q_write_i,
  input  logic                   link_q_strb_i,
  input  logic                   link_q_valid_i,
  output logic                   link_q_ready_o,
  output logic [LinkWidth-1:0]   link_p_data_o,
  output logic                   link_p_last_o,
  output logic                   link_p_valid_o,
  input  logic                   link_p_ready_i,
  output logic [AddrWidth-1:0]   req_addr_o,
  output logic [DataWidth-1:0]   req_data_o,
  output logic                   req_write_o,
  output logic [DataWidth/8-1:0] req_wstrb_o,
  output logic                   req_valid_o,
  input  logic                   req_ready_i,
  input  logic [DataWidth-1:0]   rsp_data_i,
  input  logic                   rsp_valid_i,
  output logic                   rsp_ready_o,
  output logic                   busy_o
);

  localparam int unsigned AddrBeats    = (AddrWidth + LinkWidth - 1) / LinkWidth;
  localparam int unsigned DataBeats    = DataWidth / LinkWidth;
  localparam int unsigned BeatsPerByte = 8 / LinkWidth;
  localparam int unsigned AddrBufW     = AddrBeats * LinkWidth;
  localparam int unsigned MaxBeats     = (AddrBeats > DataBeats) ? AddrBeats : DataBeats;
  localparam int unsigned CntW         = $clog2(MaxBeats + 1);

  localparam logic [CntW-1:0] AddrLast = CntW'(AddrBeats - 1);
  localparam logic [CntW-1:0] DataLast = CntW'(DataBeats - 1);

  // state    | meaning
  // RX_ADDR  | idle / collecting address beats
  // RX_DATA  | collecting write data and strobe beats
  // ISSUE    | memory request presented, waiting for req_ready_i
  // WAIT_RSP | waiting for the memory response
  // TX_RSP   | shifting the response out on the link
  typedef enum logic [2:0] {
    RX_ADDR  = 3'd0,
    RX_DATA  = 3'd1,
    ISSUE    = 3'd2,
    WAIT_RSP = 3'd3,
    TX_RSP   = 3'd4
  } state_t;

  state_t                state_q, state_d;
  logic [CntW-1:0]       cnt_q;
  logic [AddrBufW-1:0]   addr_q;
  logic [DataWidth-1:0]  data_q;
  logic [DataBeats-1:0]  strb_q;
  logic                  write_q;
  logic [DataWidth-1:0]  rsp_q;

  logic q_fire, req_fire, rsp_fire, p_fire;
  logic addr_done, data_done, tx_last, wr_now;

  assign link_q_ready_o = (state_q == RX_ADDR) || (state_q == RX_DATA);
  assign req_valid_o    = (state_q == ISSUE);
  assign rsp_ready_o    = (state_q == WAIT_RSP);
  assign link_p_valid_o = (state_q == TX_RSP);
  assign busy_o         = (state_q != RX_ADDR);

  assign q_fire   = link_q_valid_i && link_q_ready_o;
  assign req_fire = req_valid_o && req_ready_i;
  assign rsp_fire = rsp_valid_i && rsp_ready_o;
  assign p_fire   = link_p_valid_o && link_p_ready_i;

  assign addr_done = (cnt_q == AddrLast);
  assign data_done = (cnt_q == DataLast);
  // A write ack is a single beat; a read response is DataBeats beats.
  assign tx_last   = write_q ? (cnt_q == '0) : (cnt_q == DataLast);
  // The write flag is not yet registered while beat 0 is being accepted.
  assign wr_now    = (cnt_q == '0) ? link_q_write_i : write_q;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= RX_ADDR;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      RX_ADDR: begin
        if (q_fire && addr_done) begin
          state_d = wr_now ? RX_DATA : ISSUE;
        end
      end
      RX_DATA: begin
        if (q_fire && data_done) begin
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        if (req_fire) begin
          state_d = (!write_q || WriteRsp) ? WAIT_RSP : RX_ADDR;
        end
      end
      WAIT_RSP: begin
        if (rsp_fire) begin
          state_d = TX_RSP;
        end
      end
      TX_RSP: begin
        if (p_fire && tx_last) begin
          state_d = RX_ADDR;
        end
      end
      default: state_d = RX_ADDR;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cnt_q   <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      strb_q  <= '0;
      write_q <= 1'b0;
      rsp_q   <= '0;
    end else begin
      case (state_q)
        RX_ADDR: begin
          if (q_fire) begin
            // Shift in from the top so beat 0 ends up in the low bits.
            addr_q <= AddrBufW'({link_q_data_i, addr_q} >> LinkWidth);
            cnt_q  <= addr_done ? '0 : cnt_q + 1'b1;
            if (cnt_q == '0) begin
              write_q <= link_q_write_i;
              data_q  <= '0;
              strb_q  <= '0;
            end
          end
        end
        RX_DATA: begin
          if (q_fire) begin
            data_q <= DataWidth'({link_q_data_i, data_q} >> LinkWidth);
            strb_q <= DataBeats'({link_q_strb_i, strb_q} >> 1);
            cnt_q  <= data_done ? '0 : cnt_q + 1'b1;
          end
        end
        WAIT_RSP: begin
          if (rsp_fire) begin
            rsp_q <= write_q ? '0 : rsp_data_i;
            cnt_q <= '0;
          end
        end
        TX_RSP: begin
          if (p_fire) begin
            rsp_q <= rsp_q >> LinkWidth;
            cnt_q <= tx_last ? '0 : cnt_q + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign req_addr_o    = addr_q[AddrWidth-1:0];
  assign req_data_o    = data_q;
  assign req_write_o   = write_q;
  assign link_p_data_o = rsp_q[LinkWidth-1:0];
  assign link_p_last_o = (state_q == TX_RSP) && tx_last;

  for (genvar b = 0; b < DataWidth / 8; b++) begin : g_wstrb
    assign req_wstrb_o[b] = |strb_q[b*BeatsPerByte +: BeatsPerByte];
  end

endmodule

// File: doc/nibble_link_target_bridge.md
Name: nibble_link_target_bridge

Overview:
- Target-side bridge for the narrow off-chip memory link driven by the Snitch wrapper.
- Deserialises LSB-first link beats into one wide memory request (address, data, write, byte strobes) and drives a valid/ready memory port such as snitch_vip.
- Serialises the memory response back onto the link, with a last flag on the final beat.
- Generalises the fixed 4-bit/32-bit link to parametrised link, address and data widths, and adds an optional write-response mode.

Parameters:
- LinkWidth, 4, bits per link beat; legal values 1, 2, 4, 8.
- AddrWidth, 10, memory address width.
- DataWidth, 32, memory data width; must be a multiple of 8 and of LinkWidth.
- WriteRsp, 0, 1 = memory answers writes and the bridge sends a one-beat ack; 0 = writes are posted.
- Derived: AddrBeats = ceil(AddrWidth/LinkWidth).
- Derived: DataBeats = DataWidth/LinkWidth.
- Derived: BeatsPerByte = 8/LinkWidth.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  reset; synchronous, active-low.
- link_q_data_i  in  LinkWidth  request beat payload.
- link_q_write_i  in  1  write flag; sampled on first address beat only.
- link_q_strb_i  in  1  beat strobe; sampled on data beats only.
- link_q_valid_i  in  1  request beat valid.
- link_q_ready_o  out  1  request beat ready.
- link_p_data_o  out  LinkWidth  response beat payload.
- link_p_last_o  out  1  final response beat.
- link_p_valid_o  out  1  response beat valid.
- link_p_ready_i  in  1  response beat ready.
- req_addr_o  out  AddrWidth  memory request address.
- req_data_o  out  DataWidth  memory write data.
- req_write_o  out  1  memory write enable.
- req_wstrb_o  out  DataWidth/8  byte strobes.
- req_valid_o  out  1  memory request valid.
- req_ready_i  in  1  memory request ready.
- rsp_data_i  in  DataWidth  memory read data.
- rsp_valid_i  in  1  memory response valid.
- rsp_ready_o  out  1  memory response ready.
- busy_o  out  1  high in any state other than RX_ADDR.

Behaviour:
- Clock and reset: one clock, clk_i; reset rst_ni is synchronous, active-low.
- Reset values:
  - FSM goes to RX_ADDR; all data registers and beat counter are 0.
  - req_valid_o, rsp_ready_o, link_p_valid_o, link_p_last_o and busy_o are 0.
  - link_q_ready_o is 1 from the first edge with rst_ni=0.
  - Handshakes in a cycle with rst_ni=0 are ignored.
- All outputs are decoded from registered state and registers only; there is no input-to-output combinational path.
- FSM states: RX_ADDR, RX_DATA, ISSUE, WAIT_RSP, TX_RSP.
- RX_ADDR:
  - link_q_ready_o=1; each accepted beat shifts in LSB-first (beat k fills addr bits [k*LW +: LW]).
  - Bits above AddrWidth in the last beat are discarded.
  - link_q_write_i is latched on beat 0.
  - After beat AddrBeats-1: go to RX_DATA if write, else ISSUE.
- RX_DATA:
  - link_q_ready_o=1; beat k fills data bits [k*LW +: LW] and records strb bit k.
  - req_wstrb_o[b] = OR of strb bits b*BeatsPerByte .. (b+1)*BeatsPerByte-1.
  - After beat DataBeats-1: go to ISSUE.
- Reads leave req_data_o=0 and req_wstrb_o=0.
- ISSUE:
  - req_valid_o=1; all req_* outputs are held stable until req_ready_i.
  - On handshake: a read goes to WAIT_RSP; a write goes to WAIT_RSP if WriteRsp=1, else to RX_ADDR.
- WAIT_RSP:
  - rsp_ready_o=1; on rsp_valid_i, latch rsp_data_i and go to TX_RSP.
  - For a write, the latched data is forced to 0.
- TX_RSP:
  - link_p_valid_o=1; link_p_data_o = low LinkWidth bits of the shift register; shift right by LinkWidth on each link_p_ready_i.
  - Beat count is DataBeats for a read and 1 for a write ack.
  - link_p_last_o=1 on the final beat only; after the final handshake go to RX_ADDR.
- link_q_ready_o=0 in ISSUE, WAIT_RSP and TX_RSP; exactly one transaction is outstanding.
- Next-transaction timing: in the cycle after the final response handshake, link_q_ready_o=1 and a new address beat can be accepted that same cycle.
- Stalls: an idle link_q_valid_i or link_p_ready_i stalls the FSM indefinitely with no timeout; counters never wrap mid-transfer.
- Latency (minimum):
  - Read: last addr beat, then req_valid_o on the next cycle.
  - Write: last data beat, then req_valid_o on the next cycle.
  - Response: rsp handshake, then first link_p_valid_o on the next cycle.
- rsp_valid_i outside WAIT_RSP is ignored (rsp_ready_o=0).
- Reset mid-transfer, in any state: return to reset values on the next edge; partial beats are discarded.

Test Plan:
(LinkWidth=4, AddrWidth=10, DataWidth=32, WriteRsp=0 unless stated.)
1. Write: addr beats 5,A,2 with write=1; data beats F,E,E,B,D,A,E,D, all strb=1.
   -> req_addr_o=0x2A5, req_data_o=0xDEADBEEF, req_wstrb_o=0xF, req_write_o=1; no link_p_valid_o.
2. Read: addr beats 3,1,0 with write=0; memory returns 0x12345678.
   -> req_addr_o=0x013, req_write_o=0; link_p_data_o beats 8,7,6,5,4,3,2,1; link_p_last_o only on the 8th beat.
3. Partial strobe: write with strb beats 0,0,1,1,0,0,0,0.
   -> req_wstrb_o=4'b0010.
4. Backpressure: hold req_ready_i=0 for 5 cycles, then toggle link_p_ready_i every other cycle.
   -> req_* outputs stable; link_q_ready_o=0 throughout; all 8 response beats delivered exactly once, in order.
5. Reset mid-transfer: rst_ni=0 for one cycle after 2 address beats, then a full read to 0x013.
   -> busy_o=0 after the reset edge; req_addr_o=0x013 (no stale nibbles).
6. Truncation and WriteRsp=1:
   - Third address beat = F -> req_addr_o[9:8]=2'b11.
   - Write with memory rsp -> one link beat with data 0, last=1, then link_q_ready_o=1.
